seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

- Time-multiplexed seven-segment scan driver.
- Sits directly downstream of the binary-to-BCD stage (`sev_seg_disp`) and consumes its ten 5-bit digit codes D1..D10.
- Captures a digit snapshot on a load strobe and double-buffers it so the display never tears mid-frame.
- Scans one digit at a time with an inter-digit ghost-blanking interval and drives registered anode and segment lines to the board display.

## Interface

- REFRESH_DIV, 50000, clk cycles per digit slot; legal range ≥ 4.
- BLANK_CYCLES, 4, cycles at the start of each slot with all anodes inactive; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs are inverted (common-anode).
- AN_ACTIVE_LOW, 1, 1 = anode outputs are inverted.

Ports:

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; samples D1..D10.
- D1..D10  in  5 each  digit codes. D1 is the least significant digit and maps to an[0].
- an  out  10  anode enables; bit k = digit D(k+1).
- seg  out  7  segments; bit0 = a … bit6 = g.
- dp  out  1  decimal point, always off.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation

- **Digit codes:**
  - 0–9 are decimal digits.
  - 10 is minus (g only).
  - 11–31 are blank (no segments).
- **Active-high patterns:**
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F
  - minus = 0x40, blank = 0x00
- **Buffers:**
  - The pending buffer (10×5 bits) plus a pending flag are written on load.
  - The active buffer (10×5 bits) is what is scanned.
  - A load while pending is already set overwrites the pending buffer.
- **Scan:**
  - Prescaler `pcnt` counts 0..REFRESH_DIV-1.
  - Slot index `idx` counts 0..9 and advances when `pcnt` reaches its terminal count.
  - `idx` wraps 9→0; this wrap is the frame boundary.
- **Frame boundary (same edge as the wrap):**
  - If pending is set, the pending buffer is copied to the active buffer and pending is cleared.
  - frame_done pulses.
- **Simultaneous load and frame boundary:** the D1..D10 values presented with that load go straight into the active buffer and pending ends cleared. Load takes priority.
- **Slot output:**
  - While `pcnt` < BLANK_CYCLES, all anodes are inactive and seg is blank.
  - Otherwise an[idx] is active and seg shows the pattern for active[idx].
  - A blank-coded digit keeps its anode inactive.
- **Polarity:** the SEG_ACTIVE_LOW and AN_ACTIVE_LOW inversions are applied at the output registers.
- **Implementation size:** the state machine is implicit in `pcnt`/`idx`; no other states.

## Timing

- **Output latency:** an, seg, dp and frame_done are registered, lagging internal `pcnt`/`idx` state by exactly 1 cycle.
- **Load-to-display latency:** a load first appears at the start of the next frame, i.e. within 10·REFRESH_DIV + 1 cycles. It is never visible mid-frame.
- **frame_done period:** exactly 10·REFRESH_DIV cycles.
- **Reset values (asynchronous, while rst_n = 0):**
  - `pcnt` = 0, `idx` = 0, active = all 0, pending = all 0, pending flag = 0.
  - an = all inactive (0x3FF with AN_ACTIVE_LOW = 1).
  - seg = blank (0x7F with SEG_ACTIVE_LOW = 1).
  - dp = inactive, frame_done = 0.
- **After reset release:** the first slot (digit 0) begins blanked. Reset mid-frame discards both buffers.
- **load held high for several cycles:** each cycle re-samples D1..D10; the last sample wins.

## Configuration

- **SEG_LZB_EN defined:** leading-zero blanking.
  - Digits above the most significant non-zero digit of the active buffer are treated as blank (anode inactive).
  - Digit 0 is never blanked, so all-zero shows a single "0".
  - Minus (code 10) counts as non-zero.
  - The blank mask is recomputed combinationally from the active buffer.
- **SEG_LZB_EN undefined:** every digit is shown as coded, including leading zeros.

## Test plan

Benches use REFRESH_DIV = 8, BLANK_CYCLES = 2, both polarities active-low.

1. **Reset:**
   - Stimulus: assert rst_n = 0 mid-scan.
   - Response: an = 0x3FF and seg = 0x7F immediately; frame_done = 0.
   - After release: first frame_done after 80 cycles; slot 0 shows "0" (seg = 0x40, an = 0x3FE).
2. **Load 12345:**
   - Stimulus: load D1 = 5, D2 = 4, D3 = 3, D4 = 2, D5 = 1, rest 0.
   - Response: next frame slot 0 gives seg = 0x12, an = 0x3FE; slot 4 gives seg = 0x79, an = 0x3EF.
   - Slot cycles 0–1 are always an = 0x3FF.
3. **Leading zeros (12345):**
   - With SEG_LZB_EN: slots 5–9 give an = 0x3FF.
   - Without SEG_LZB_EN: slot 5 gives seg = 0x40, an = 0x3DF.
4. **Tear-free update:**
   - Stimulus: load 99 in slot 3, then load 7 in slot 6.
   - Response: old value persists to the wrap, then only 7 is shown. Exactly one frame_done per 80 cycles.
5. **Coincident load:**
   - Stimulus: load on the same cycle as the 9→0 wrap.
   - Response: new digits are shown in that same frame's slot 0 (1-cycle output lag) and pending stays 0.
6. **Codes 10/15:**
   - Stimulus: D1 = 10, D2 = 15.
   - Response: slot 0 seg = 0x3F (minus); slot 1 an = 0x3FF.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed ten-digit seven-segment scan driver. Digit codes from the
//   binary-to-BCD stage are captured on `load` into a pending buffer and moved
//   into the scanned (active) buffer only at a frame boundary, so a frame never
//   shows a mix of old and new digits. Each digit slot opens with a short
//   all-off interval to suppress ghosting between neighbouring digits.
//
//   Optional feature: define SEG_LZB_EN for leading-zero blanking.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        strobe; samples D1..D10 (held high: last sample wins)
//   D1..D10     5-bit digit codes (0-9 digit, 10 minus, 11-31 blank); D1 -> an[0]
//   an[9:0]     registered anode enables, bit k = digit D(k+1)
//   seg[6:0]    registered segments, bit0 = a .. bit6 = g
//   dp          decimal point, held inactive
//   frame_done  one-cycle pulse per frame wrap (registered)
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] D1,
    input  logic [4:0] D2,
    input  logic [4:0] D3,
    input  logic [4:0] D4,
    input  logic [4:0] D5,
    input  logic [4:0] D6,
    input  logic [4:0] D7,
    input  logic [4:0] D8,
    input  logic [4:0] D9,
    input  logic [4:0] D10,
    output logic [9:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);
    localparam int unsigned   PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_N   = PW'(BLANK_CYCLES);
    localparam logic [9:0]    AN_OFF    = AN_ACTIVE_LOW ? 10'h3FF : 10'h000;
    localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    function automatic logic [6:0] seg_pattern(input logic [4:0] code);
        case (code)
            5'd0:    seg_pattern = 7'h3F;
            5'd1:    seg_pattern = 7'h06;
            5'd2:    seg_pattern = 7'h5B;
            5'd3:    seg_pattern = 7'h4F;
            5'd4:    seg_pattern = 7'h66;
            5'd5:    seg_pattern = 7'h6D;
            5'd6:    seg_pattern = 7'h7D;
            5'd7:    seg_pattern = 7'h07;
            5'd8:    seg_pattern = 7'h7F;
            5'd9:    seg_pattern = 7'h6F;
            5'd10:   seg_pattern = 7'h40;
            default: seg_pattern = 7'h00;
        endcase
    endfunction

    logic [9:0][4:0] din;
    assign din = {D10, D9, D8, D7, D6, D5, D4, D3, D2, D1};

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [9:0][4:0] act_q, act_d, pend_q, pend_d;
    logic            pflag_q, pflag_d;
    logic [9:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q;
    logic            fd_q;
    logic            slot_end, wrap;
    logic [9:0]      show;
    logic [4:0]      cur;
    logic            lit;
    logic [9:0]      an_hi;
    logic [6:0]      seg_hi;

    assign slot_end = (pcnt_q == PCNT_LAST);
    assign wrap     = slot_end && (idx_q == 4'd9);

    // Scan counters: pcnt is the prescaler, idx the digit slot.
    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        idx_d  = idx_q;
        if (slot_end) begin
            pcnt_d = '0;
            idx_d  = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
        end
    end

    // Double buffer. A load coinciding with the wrap bypasses pending so the
    // freshest digits land in the frame that is just starting.
    always_comb begin
        act_d   = act_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        if (load) begin
            if (wrap) begin
                act_d   = din;
                pflag_d = 1'b0;
            end else begin
                pend_d  = din;
                pflag_d = 1'b1;
            end
        end else if (wrap && pflag_q) begin
            act_d   = pend_q;
            pflag_d = 1'b0;
        end
    end

`ifdef SEG_LZB_EN
    // Show digit k only if some digit at or above k is non-zero; digit 0 always.
    logic seen;
    always_comb begin
        seen = 1'b0;
        show = '0;
        for (int k = 9; k >= 0; k--) begin
            seen    = seen | (act_q[k] != 5'd0);
            show[k] = seen | (k == 0);
        end
    end
`else
    assign show = '1;
`endif

    // Blank-coded digits (>10) keep their anode off as well as their segments.
    always_comb begin
        cur    = act_q[idx_q];
        lit    = (pcnt_q >= BLANK_N) && show[idx_q] && (cur <= 5'd10);
        an_hi  = lit ? (10'b1 << idx_q) : 10'b0;
        seg_hi = lit ? seg_pattern(cur) : 7'b0;
        an_d   = AN_ACTIVE_LOW ? ~an_hi : an_hi;
        seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            idx_q   <= '0;
            act_q   <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_ACTIVE_LOW;
            fd_q    <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= SEG_ACTIVE_LOW;
            fd_q    <= wrap;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2,
// both polarities active-low). A reference model derives slot position from the
// number of clock edges since reset and pushes the expected outputs per edge; a
// monitor on the falling edge pops and compares.
module tb_seg_scan_driver;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 10 * RD;

    typedef struct {
        logic [9:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [4:0] d [10];
    logic [9:0] an;
    logic [6:0] seg;
    logic       dp, frame_done;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         n = 0;
    logic [4:0] m_act [10];
    logic [4:0] m_pend [10];
    bit         m_flag = 0;
    exp_t       q[$];
    logic [6:0] pat [11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40};

    seg_scan_driver #(
        .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]), .D5(d[4]),
        .D6(d[5]), .D7(d[6]), .D8(d[7]), .D9(d[8]), .D10(d[9]),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at edge %0d t=%0t", nm, act, exp, n, $time);
        end
    endtask

    // Expected registered outputs for the edge that sees the design at position n.
    function automatic exp_t expect_out(int pos);
        exp_t e;
        int pc, slot, top;
        logic [4:0] c;
        bit lit;
        pc   = pos % RD;
        slot = (pos / RD) % 10;
        c    = m_act[slot];
        top  = 0;
        for (int k = 0; k < 10; k++) if (m_act[k] != 0) top = k;
        lit = (pc >= BC) && (c <= 10);
`ifdef SEG_LZB_EN
        if (slot > top) lit = 0;
`endif
        e.an  = 10'h3FF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = (pos % FRAME) == FRAME - 1;
        if (lit) begin
            e.an[slot] = 1'b0;
            e.seg      = ~pat[c];
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            m_flag = 0;
            for (int k = 0; k < 10; k++) begin
                m_act[k]  = 5'd0;
                m_pend[k] = 5'd0;
            end
            q.delete();
        end else begin
            bit wrap;
            q.push_back(expect_out(n));
            wrap = (n % FRAME) == FRAME - 1;
            if (load) begin
                if (wrap) begin
                    m_act = d;
                    m_flag = 0;
                end else begin
                    m_pend = d;
                    m_flag = 1;
                end
            end else if (wrap && m_flag) begin
                m_act = m_pend;
                m_flag = 0;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("an", 32'(an), 32'(e.an));
            chk("seg", 32'(seg), 32'(e.seg));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("dp", 32'(dp), 32'(e.dp));
        end
    end

    task automatic step(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_digits(input int v0, input int v1, input int v2, input int v3, input int v4);
        for (int k = 0; k < 10; k++) d[k] = 5'd0;
        d[0] = 5'(v0); d[1] = 5'(v1); d[2] = 5'(v2); d[3] = 5'(v3); d[4] = 5'(v4);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    // Advance until the next edge sees frame position `pos`; expired bound is a failure.
    task automatic wait_pos(input int pos);
        int budget;
        budget = 2 * FRAME;
        while ((n % FRAME) != pos && budget > 0) begin
            step(1);
            budget--;
        end
        chk("wait_pos_timeout", 32'(budget == 0), 32'd0);
    endtask

    task automatic rand_digits();
        int nd;
        nd = $urandom_range(0, 10);
        for (int k = 0; k < 10; k++) begin
            if (k < nd)
                d[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31))
                                                   : 5'($urandom_range(0, 9));
            else
                d[k] = 5'd0;
        end
    endtask

    initial begin
        for (int k = 0; k < 10; k++) d[k] = 5'd0;
        step(3);
        chk("reset_an", 32'(an), 32'h3FF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        step(FRAME + 20);

        // 12345
        set_digits(5, 4, 3, 2, 1);
        pulse_load();
        step(2 * FRAME);

        // tear-free: 99 in slot 3, then 7 in slot 6 of the same frame
        wait_pos(3 * RD + 3);
        set_digits(9, 9, 0, 0, 0);
        pulse_load();
        wait_pos(6 * RD + 1);
        set_digits(7, 0, 0, 0, 0);
        pulse_load();
        step(2 * FRAME);

        // coincident load with the wrap
        wait_pos(FRAME - 1);
        set_digits(8, 6, 0, 4, 0);
        pulse_load();
        step(FRAME + 10);

        // minus and a blank code
        set_digits(10, 15, 0, 0, 0);
        pulse_load();
        step(2 * FRAME);

        // reset mid-scan
        step($urandom_range(5, 60));
        rst_n = 1'b0;
        #1;
        chk("midreset_an", 32'(an), 32'h3FF);
        chk("midreset_seg", 32'(seg), 32'h7F);
        chk("midreset_fd", 32'(frame_done), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(FRAME + 20);

        // random loads, some held for several cycles, some on the wrap
        for (int it = 0; it < 30; it++) begin
            int len;
            if ($urandom_range(0, 4) == 0) wait_pos(FRAME - 1);
            else step($urandom_range(0, 60));
            len = $urandom_range(1, 3);
            load = 1'b1;
            for (int j = 0; j < len; j++) begin
                rand_digits();
                step(1);
            end
            load = 1'b0;
        end
        step(2 * FRAME + 10);

        chk("enough_checks", 32'(checks > 1000), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
